// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: merges stall requests, sequences front-end flushes
// after taken jumps, parks the core for debug halt and counts stalled cycles.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_ex_i,
    input  logic        hold_flag_rib_i,
    input  logic        hold_flag_clint_i,
    input  logic        jtag_halt_flag_i,
    input  logic        stall_cnt_clr_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        halted_o,
    output logic [31:0] stall_cnt_o,
    output logic [1:0]  dbg_state_o
);

    // Hold encoding shared with pc_reg/if_id/id_ex; level 2 (hold if) is never requested here.
    localparam logic [2:0] HOLD_NONE  = 3'd0;
    localparam logic [2:0] HOLD_PC    = 3'd1;
    localparam logic [2:0] HOLD_ID    = 3'd3;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_flush_cnt;
    logic [2:0]  w_flush_cnt_nxt;
    logic        r_halted;
    logic [31:0] r_stall_cnt;
    logic [2:0]  w_req_level;
    logic [2:0]  w_state_level;
    logic [2:0]  w_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_halted    <= (w_state_nxt == ST_HALT);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            ST_RUN: begin
                if (jump_flag_i) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end else if (jtag_halt_flag_i && !hold_flag_ex_i && !hold_flag_clint_i) begin
                    // Halt waits for any in-flight multi-cycle or interrupt sequence.
                    w_state_nxt = ST_HALT;
                end
            end
            ST_FLUSH: begin
                if (jump_flag_i) begin
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end else if (r_flush_cnt <= 3'd1) begin
                    w_state_nxt     = ST_RUN;
                    w_flush_cnt_nxt = 3'd0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                end
            end
            ST_HALT: begin
                if (jump_flag_i) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end else if (!jtag_halt_flag_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt     = ST_RUN;
                w_flush_cnt_nxt = 3'd0;
            end
        endcase
    end

    always_comb begin
        w_req_level = HOLD_NONE;
        if (jump_flag_i || hold_flag_clint_i || hold_flag_ex_i) begin
            w_req_level = HOLD_ID;
        end else if (hold_flag_rib_i) begin
            w_req_level = HOLD_PC;
        end
        w_state_level = (r_state == ST_RUN) ? HOLD_NONE : HOLD_ID;
        w_hold        = (w_req_level > w_state_level) ? w_req_level : w_state_level;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (stall_cnt_clr_i) begin
            r_stall_cnt <= 32'd0;
        end else if ((w_hold != HOLD_NONE) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign hold_flag_o = w_hold;
    assign jump_flag_o = jump_flag_i;
    assign jump_addr_o = jump_flag_i ? jump_addr_i : 32'd0;
    assign halted_o    = r_halted;
    assign stall_cnt_o = r_stall_cnt;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: driver pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_ex_i;
    logic        hold_flag_rib_i;
    logic        hold_flag_clint_i;
    logic        jtag_halt_flag_i;
    logic        stall_cnt_clr_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        halted_o;
    logic [31:0] stall_cnt_o;
    logic [1:0]  dbg_state_o;

    // {hold(3), jump_flag(1), jump_addr(32), halted(1), stall_cnt(32)}
    logic [68:0] exp_q[$];
    string       tag_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    string       cur_test = "init";
    int          vec_idx  = 0;

    pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .jump_flag_i      (jump_flag_i),
        .jump_addr_i      (jump_addr_i),
        .hold_flag_ex_i   (hold_flag_ex_i),
        .hold_flag_rib_i  (hold_flag_rib_i),
        .hold_flag_clint_i(hold_flag_clint_i),
        .jtag_halt_flag_i (jtag_halt_flag_i),
        .stall_cnt_clr_i  (stall_cnt_clr_i),
        .hold_flag_o      (hold_flag_o),
        .jump_flag_o      (jump_flag_o),
        .jump_addr_o      (jump_addr_o),
        .halted_o         (halted_o),
        .stall_cnt_o      (stall_cnt_o),
        .dbg_state_o      (dbg_state_o)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: called just after a rising edge; applies inputs for this cycle,
    // queues the expected outputs, then advances to just after the next edge.
    task automatic step(input logic jf, input logic [31:0] ja, input logic ex,
                        input logic rib, input logic clint, input logic halt,
                        input logic clr, input logic [2:0] e_hold,
                        input logic e_halted, input logic [31:0] e_stall);
        jump_flag_i       = jf;
        jump_addr_i       = ja;
        hold_flag_ex_i    = ex;
        hold_flag_rib_i   = rib;
        hold_flag_clint_i = clint;
        jtag_halt_flag_i  = halt;
        stall_cnt_clr_i   = clr;
        exp_q.push_back({e_hold, jf, (jf ? ja : 32'h0), e_halted, e_stall});
        tag_q.push_back($sformatf("%s#%0d", cur_test, vec_idx));
        vec_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [2:0] e_hold, input logic e_halted, input logic [31:0] e_stall);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_hold, e_halted, e_stall);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [68:0] e;
        logic [68:0] a;
        string       t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {hold_flag_o, jump_flag_o, jump_addr_o, halted_o, stall_cnt_o};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got hold=%0d jf=%0b addr=%h halted=%0b stall=%h, want hold=%0d jf=%0b addr=%h halted=%0b stall=%h",
                         t, a[68:66], a[65], a[64:33], a[32], a[31:0],
                         e[68:66], e[65], e[64:33], e[32], e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        jump_flag_i = 1'b0; jump_addr_i = 32'h0; hold_flag_ex_i = 1'b0;
        hold_flag_rib_i = 1'b0; hold_flag_clint_i = 1'b0; jtag_halt_flag_i = 1'b0;
        stall_cnt_clr_i = 1'b0;
        @(posedge clk);
        #1;

        // During reset only the request level reaches hold_flag_o
        cur_test = "reset";
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'd0);
        idle(3'd0, 1'b0, 32'd0);
        rst = 1'b0;

        cur_test = "idle";
        for (int i = 0; i < 10; i++) idle(3'd0, 1'b0, 32'd0);

        cur_test = "jump";
        step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 32'd0);
        idle(3'd3, 1'b0, 32'd1);
        idle(3'd3, 1'b0, 32'd2);
        idle(3'd0, 1'b0, 32'd3);
        idle(3'd0, 1'b0, 32'd3);

        cur_test = "b2b_jump";
        step(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 32'd3);
        step(1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 32'd4);
        idle(3'd3, 1'b0, 32'd5);
        idle(3'd3, 1'b0, 32'd6);
        idle(3'd0, 1'b0, 32'd7);
        idle(3'd0, 1'b0, 32'd7);

        cur_test = "rib_ex_clint";
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 32'd7);
        for (int i = 0; i < 5; i++)
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'(i));
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 32'd5);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 32'd6);
        idle(3'd0, 1'b0, 32'd7);

        cur_test = "clr_wins";
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 32'd7);
        idle(3'd0, 1'b0, 32'd0);

        cur_test = "halt_deferred_ex";
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 32'(i));
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'd4);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 32'd4);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 32'd5);
        idle(3'd3, 1'b1, 32'd6);
        idle(3'd0, 1'b0, 32'd7);
        idle(3'd0, 1'b0, 32'd7);

        cur_test = "halt_in_flush";
        step(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 32'd7);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 32'd8);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 32'd9);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'd10);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 32'd10);
        step(1'b1, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 32'd11);
        idle(3'd3, 1'b0, 32'd12);
        idle(3'd3, 1'b0, 32'd13);
        idle(3'd0, 1'b0, 32'd14);

        cur_test = "saturate";
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'hFFFF_FFFE);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'hFFFF_FFFF);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'hFFFF_FFFF);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 32'hFFFF_FFFF);
        idle(3'd0, 1'b0, 32'd0);

        cur_test = "rst_mid_flush";
        step(1'b1, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 32'd0);
        rst = 1'b1;
        idle(3'd0, 1'b0, 32'd0);
        rst = 1'b0;
        idle(3'd0, 1'b0, 32'd0);
        idle(3'd0, 1'b0, 32'd0);

        cur_test = "rst_mid_halt";
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 32'd0);
        rst = 1'b1;
        idle(3'd0, 1'b0, 32'd0);
        rst = 1'b0;
        idle(3'd0, 1'b0, 32'd0);
        idle(3'd0, 1'b0, 32'd0);

        // Drain any expectation the monitor has not reached yet
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles of front-end flush after a taken jump; legal range 1..7.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port jump_flag_i  input  1  taken jump/branch from execute.
REQ-005 SHALL have port jump_addr_i  input  32  jump target.
REQ-006 SHALL have port hold_flag_ex_i  input  1  execute multi-cycle op (divide) busy.
REQ-007 SHALL have port hold_flag_rib_i  input  1  bus busy / instruction fetch not granted.
REQ-008 SHALL have port hold_flag_clint_i  input  1  interrupt controller entering/leaving handler.
REQ-009 SHALL have port jtag_halt_flag_i  input  1  debug halt request, level.
REQ-010 SHALL have port stall_cnt_clr_i  input  1  synchronous clear of stall counter.
REQ-011 SHALL have port hold_flag_o  output  3  pipeline hold level to pc_reg, if_id, id_ex: Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3.
REQ-012 SHALL have port jump_flag_o  output  1  jump request to pc_reg.
REQ-013 SHALL have port jump_addr_o  output  32  jump target to pc_reg.
REQ-014 SHALL have port halted_o  output  1  core halted for debug (registered).
REQ-015 SHALL have port stall_cnt_o  output  32  count of cycles with hold_flag_o != Hold_None (registered).

Function
REQ-016 SHALL implement FSM states RUN, FLUSH, HALT, plus a 3-bit flush counter.
REQ-017 SHALL pass jump_flag_o = jump_flag_i and jump_addr_o = jump_addr_i combinationally, same cycle, in every state; jump_addr_o = 0 when jump_flag_i = 0.
REQ-018 SHALL compute request level: Hold_Id if jump_flag_i, hold_flag_clint_i or hold_flag_ex_i; else Hold_Pc if hold_flag_rib_i; else Hold_None.
REQ-019 SHALL compute state level: Hold_Id in FLUSH and HALT, Hold_None in RUN.
REQ-020 SHALL drive hold_flag_o = max(request level, state level), combinationally.
REQ-021 RUN: jump_flag_i=1 -> FLUSH, counter loaded with FLUSH_CYCLES; takes priority over jtag_halt_flag_i.
REQ-022 RUN: jtag_halt_flag_i=1, jump_flag_i=0, hold_flag_ex_i=0, hold_flag_clint_i=0 -> HALT; else stay RUN (halt deferred until in-flight op completes).
REQ-023 FLUSH: counter decrements each cycle; when counter==1 and no new jump, next state RUN; counter reaches 0.
REQ-024 FLUSH: jump_flag_i=1 reloads counter with FLUSH_CYCLES and stays FLUSH (back-to-back jumps).
REQ-025 FLUSH: jtag_halt_flag_i SHALL NOT be honoured until return to RUN.
REQ-026 HALT: halted_o=1 registered on the cycle after entering HALT; jtag_halt_flag_i=0 -> RUN next cycle, halted_o=0 same edge.
REQ-027 HALT: jump_flag_i=1 (e.g. debug-injected) -> FLUSH, halted_o cleared.
REQ-028 Stall counter: +1 on each cycle hold_flag_o != Hold_None; saturates at 0xFFFFFFFF; stall_cnt_clr_i=1 forces 0, clear wins over increment.

Reset
REQ-029 rst=1 SHALL asynchronously force state RUN, flush counter 0, halted_o=0, stall_cnt_o=0; hold_flag_o then reflects only request level.
REQ-030 Reset asserted mid-FLUSH or mid-HALT SHALL abandon the sequence with no residual hold after release.

Verification
REQ-031 Reset then idle inputs 10 cycles -> hold_flag_o=0, jump_flag_o=0, halted_o=0, stall_cnt_o=0.
REQ-032 Single-cycle jump_flag_i=1, jump_addr_i=0x0000_0100, FLUSH_CYCLES=2 -> jump_flag_o=1, addr 0x100 same cycle; hold_flag_o=3 for 3 cycles (jump + 2 flush); stall_cnt_o=3.
REQ-033 Jump, then second jump on first FLUSH cycle -> hold_flag_o=3 for 4 consecutive cycles total, then 0.
REQ-034 hold_flag_rib_i=1 alone 5 cycles -> hold_flag_o=1 each cycle; with hold_flag_ex_i=1 concurrently -> 3.
REQ-035 jtag_halt_flag_i=1 while hold_flag_ex_i=1 for 4 cycles -> HALT entered only after ex drops; halted_o=1 one cycle later; drop halt -> halted_o=0, hold_flag_o=0 next cycle.
REQ-036 Force stall_cnt_o to 0xFFFF_FFFE via sustained hold, hold 3 more cycles -> saturates at 0xFFFF_FFFF; assert stall_cnt_clr_i with hold active -> 0; assert rst mid-FLUSH -> hold_flag_o=0 immediately.
